// File: rtl/seg_display_arbiter.sv
// Seven-segment display arbiter.
// Shares a 4-digit display between a persistent background value and one-shot
// timed messages. Runs the message-hold and post-message gap timers, and
// generates the free-running digit-scan clock for the quad display driver.
//
// Request handshake: msg_req is a level held by the requester until it sees
// msg_ack. msg_ack is a single-cycle pulse issued on the edge that accepts the
// request (only from SHOW_BG). msg_val is sampled on that same edge. While
// SHOW_MSG or GAP is active, requests are left pending and not acknowledged.
module seg_display_arbiter #(
  parameter int HOLD_CYCLES = 100000000,
  parameter int GAP_CYCLES  = 50000000,
  parameter int SCAN_DIV    = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bg_val,
  input  logic        msg_req,
  input  logic [15:0] msg_val,
  input  logic        msg_abort,
  output logic        msg_ack,
  output logic        busy,
  output logic        src_msg,
  output logic [3:0]  num0,
  output logic [3:0]  num1,
  output logic [3:0]  num2,
  output logic [3:0]  num3,
  output logic        scan_clk
);

  // One timer serves both hold and gap phases, so it is sized for the larger.
  localparam int TMR_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(TMR_MAX + 1);
  localparam int SW      = $clog2(SCAN_DIV + 1);
  localparam bit HAS_GAP = (GAP_CYCLES > 0);

  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST  = HAS_GAP ? TW'(GAP_CYCLES - 1) : '0;
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    SHOW_BG  = 2'd0,
    SHOW_MSG = 2'd1,
    GAP      = 2'd2
  } state_t;

  // state is the FSM handle that checkers and waveforms bind to.
  state_t        state;
  logic [15:0]   msg_latch;
  logic [15:0]   disp;
  logic [TW-1:0] tmr_cnt;
  logic [SW-1:0] scan_cnt;

  assign num0 = disp[3:0];
  assign num1 = disp[7:4];
  assign num2 = disp[11:8];
  assign num3 = disp[15:12];

  // Arbitration FSM with registered display source, ack, busy and src flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SHOW_BG;
      msg_latch <= '0;
      disp      <= '0;
      tmr_cnt   <= '0;
      msg_ack   <= 1'b0;
      busy      <= 1'b0;
      src_msg   <= 1'b0;
    end else begin
      msg_ack <= 1'b0;
      case (state)
        SHOW_BG: begin
          if (msg_req) begin
            state     <= SHOW_MSG;
            msg_latch <= msg_val;
            disp      <= msg_val;
            msg_ack   <= 1'b1;
            tmr_cnt   <= '0;
            busy      <= 1'b1;
            src_msg   <= 1'b1;
          end else begin
            disp    <= bg_val;
            busy    <= 1'b0;
            src_msg <= 1'b0;
          end
        end
        SHOW_MSG: begin
          // Abort and hold expiry take the same exit, so abort wins trivially.
          if (msg_abort || (tmr_cnt == HOLD_LAST)) begin
            tmr_cnt <= '0;
            disp    <= bg_val;
            src_msg <= 1'b0;
            if (HAS_GAP) begin
              state <= GAP;
              busy  <= 1'b1;
            end else begin
              state <= SHOW_BG;
              busy  <= 1'b0;
            end
          end else begin
            tmr_cnt <= tmr_cnt + 1'b1;
            disp    <= msg_latch;
            src_msg <= 1'b1;
            busy    <= 1'b1;
          end
        end
        GAP: begin
          disp    <= bg_val;
          src_msg <= 1'b0;
          if (tmr_cnt == GAP_LAST) begin
            state   <= SHOW_BG;
            tmr_cnt <= '0;
            busy    <= 1'b0;
          end else begin
            tmr_cnt <= tmr_cnt + 1'b1;
            busy    <= 1'b1;
          end
        end
        default: begin
          state   <= SHOW_BG;
          tmr_cnt <= '0;
          disp    <= bg_val;
          busy    <= 1'b0;
          src_msg <= 1'b0;
        end
      endcase
    end
  end

  // Free-running scan divider: toggle scan_clk every SCAN_DIV cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_clk <= 1'b0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_clk <= ~scan_clk;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

endmodule
